// File: rtl/is_uart_rx_sampler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : is_uart_rx_sampler
// Brief    : UART 8N1 receive front-end: 2-flop synchroniser, start detection,
//            mid-bit 3-sample majority vote, LSB-first deserialiser.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module is_uart_rx_sampler #(
  parameter int RATIO  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              uart_ce_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              rx_ferr_o,
  output logic              rx_busy_o
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] c_cnt_s0   = CW'(RATIO/2 - 1);
  localparam logic [CW-1:0] c_cnt_s1   = CW'(RATIO/2);
  localparam logic [CW-1:0] c_cnt_dec  = CW'(RATIO/2 + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(RATIO - 1);
  localparam logic [BW-1:0] c_bit_last = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic              r_sync1;
  logic              r_rx_s;
  logic              r_armed;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_s0;
  logic              r_s1;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ferr;

  state_t            w_state_nxt;
  logic              w_armed_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [BW-1:0]     w_bit_idx_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_s0_nxt;
  logic              w_s1_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_valid_nxt;
  logic              w_ferr_nxt;
  logic              w_maj;
  logic              w_wrap;
  logic              w_decide;

  // Synchroniser idles high so reset never looks like a start edge
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_rx_s  <= r_sync1;
    end
  end

  assign w_maj    = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
  assign w_wrap   = (r_cnt == c_cnt_last);
  assign w_decide = (r_cnt == c_cnt_dec);

  always_comb begin
    w_state_nxt   = r_state;
    w_armed_nxt   = r_armed;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_s0_nxt      = r_s0;
    w_s1_nxt      = r_s1;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;

    if (uart_ce_i) begin
      // A high line must be seen after reset before a start edge counts
      if (r_rx_s) begin
        w_armed_nxt = 1'b1;
      end
      if (r_state != S_IDLE) begin
        w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
        if (r_cnt == c_cnt_s0) w_s0_nxt = r_rx_s;
        if (r_cnt == c_cnt_s1) w_s1_nxt = r_rx_s;
      end

      case (r_state)
        S_IDLE: begin
          if (r_armed && !r_rx_s) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = CW'(1);
          end
        end
        S_START: begin
          if (w_decide && w_maj) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_wrap) begin
            w_state_nxt   = S_DATA;
            w_bit_idx_nxt = '0;
          end
        end
        S_DATA: begin
          if (w_decide) begin
            w_shift_nxt = {w_maj, r_shift[DATA_W-1:1]};
          end
          if (w_wrap) begin
            if (r_bit_idx == c_bit_last) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bit_idx_nxt = r_bit_idx + 1'b1;
            end
          end
        end
        S_STOP: begin
          // Leave at the decision tick so a start edge right after is caught
          if (w_decide) begin
            if (w_maj) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_ferr_nxt  = 1'b1;
            end
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_armed   <= 1'b0;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_armed   <= w_armed_nxt;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_s0      <= w_s0_nxt;
      r_s1      <= w_s1_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  assign rx_data_o  = r_data;
  assign rx_valid_o = r_valid;
  assign rx_ferr_o  = r_ferr;
  assign rx_busy_o  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_is_uart_rx_sampler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_is_uart_rx_sampler
// Brief    : Self-checking bench: directed frame table, hand-written corner
//            sequences and random frames against a line-level decode model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_is_uart_rx_sampler;

  localparam int RATIO    = 8;
  localparam int DATA_W   = 8;
  localparam int FRAME_SL = 10 * RATIO;
  localparam int LAT_CLK  = (9 * RATIO + RATIO/2 + 1) * 4;

  logic              clk;
  logic              rstn_i;
  logic              uart_ce;
  logic              rx_i;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_ferr_o;
  logic              rx_busy_o;

  is_uart_rx_sampler #(.RATIO(RATIO), .DATA_W(DATA_W)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn_i),
    .uart_ce_i  (uart_ce),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ferr_o  (rx_ferr_o),
    .rx_busy_o  (rx_busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oversampling tick every 4 clk
  int div = 0;
  initial uart_ce = 1'b0;
  always @(negedge clk) begin
    div     = (div == 3) ? 0 : div + 1;
    uart_ce = (div == 0);
  end

  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_valid = 0, n_ferr = 0, n_both = 0, n_long = 0, n_busy_rise = 0;
  int   cyc = 0, t_busy = 0, lat = -1;
  logic valid_q = 1'b0, ferr_q = 1'b0, busy_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rx_valid_o) n_valid++;
    if (rx_ferr_o) n_ferr++;
    if (rx_valid_o && rx_ferr_o) n_both++;
    if ((rx_valid_o && valid_q) || (rx_ferr_o && ferr_q)) n_long++;
    if (rx_busy_o && !busy_q) begin
      n_busy_rise++;
      t_busy = cyc;
    end
    if (rx_valid_o && !valid_q) lat = cyc - t_busy;
    valid_q = rx_valid_o;
    ferr_q  = rx_ferr_o;
    busy_q  = rx_busy_o;
  end

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (!uart_ce);
    @(negedge clk);
  endtask

  // Line image of one frame, one entry per tick slot; nbit<0 means no noise
  function automatic logic [FRAME_SL-1:0] build_line(input logic [7:0] d,
      input logic stop, input int nbit, input int nslot);
    logic [FRAME_SL-1:0] lv;
    logic v;
    for (int k = 0; k < 10; k++) begin
      v = (k == 0) ? 1'b0 : (k == 9) ? stop : d[k-1];
      for (int j = 0; j < RATIO; j++) lv[k*RATIO + j] = v;
    end
    if (nbit >= 0) lv[nbit*RATIO + nslot] = ~lv[nbit*RATIO + nslot];
    return lv;
  endfunction

  // Reference decode: majority of the three mid-bit slots of each bit
  function automatic logic maj_of(input logic [FRAME_SL-1:0] lv, input int k);
    int ones;
    ones = 0;
    for (int j = RATIO/2 - 1; j <= RATIO/2 + 1; j++) ones += int'(lv[k*RATIO + j]);
    return (ones >= 2);
  endfunction

  task automatic drive_slots(input logic [FRAME_SL-1:0] lv, input int n);
    for (int i = 0; i < n; i++) begin
      rx_i = lv[i];
      wait_tick();
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input logic stop,
      input int nbit, input int nslot, input int gap,
      input logic exp_v, input logic exp_f, input logic [7:0] exp_d);
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    drive_slots(build_line(d, stop, nbit, nslot), FRAME_SL);
    rx_i = 1'b1;
    repeat (gap) wait_tick();
    #1;
    check({name, " valid"}, n_valid - v0, int'(exp_v));
    check({name, " ferr"}, n_ferr - f0, int'(exp_f));
    check({name, " data"}, int'(rx_data_o), int'(exp_d));
    check({name, " busy"}, int'(rx_busy_o), 0);
    if (exp_v) check({name, " latency"}, lat, LAT_CLK);
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       stop;
    int         nbit;
    int         nslot;
    int         gap;
    logic       exp_v;
    logic       exp_f;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [FRAME_SL-1:0] lv;
    logic [7:0] model_d, rd;
    logic       rs, sm;
    int         rb, rsl, rg, v0, f0, b0;

    vecs[0] = '{"a5",      8'hA5, 1'b1, -1, 0, 12, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{"55 ferr", 8'h55, 1'b0, -1, 0, 12, 1'b0, 1'b1, 8'hA5};
    vecs[2] = '{"81 noise",8'h81, 1'b1,  1, 4, 12, 1'b1, 1'b0, 8'h81};
    vecs[3] = '{"81 noise7",8'h81,1'b1,  8, 3, 12, 1'b1, 1'b0, 8'h81};
    vecs[4] = '{"b2b 00",  8'h00, 1'b1, -1, 0,  0, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{"b2b ff",  8'hFF, 1'b1, -1, 0, 12, 1'b1, 1'b0, 8'hFF};

    rstn_i = 1'b0;
    rx_i   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset data",  int'(rx_data_o),  0);
    check("reset valid", int'(rx_valid_o), 0);
    check("reset ferr",  int'(rx_ferr_o),  0);
    check("reset busy",  int'(rx_busy_o),  0);
    rstn_i = 1'b1;
    repeat (4) wait_tick();

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].name, vecs[i].data, vecs[i].stop, vecs[i].nbit, vecs[i].nslot,
                vecs[i].gap, vecs[i].exp_v, vecs[i].exp_f, vecs[i].exp_d);

    // Two-tick low glitch: start is entered, then rejected at the decision tick
    v0 = n_valid; f0 = n_ferr; b0 = n_busy_rise;
    rx_i = 1'b0;
    repeat (2) wait_tick();
    rx_i = 1'b1;
    repeat (12) wait_tick();
    #1;
    check("glitch busy rise", n_busy_rise - b0, 1);
    check("glitch valid", n_valid - v0, 0);
    check("glitch ferr", n_ferr - f0, 0);
    check("glitch busy", int'(rx_busy_o), 0);
    run_frame("3c", 8'h3C, 1'b1, -1, 0, 12, 1'b1, 1'b0, 8'h3C);

    // Reset during data bit 3 of 0x5A
    v0 = n_valid; f0 = n_ferr;
    lv = build_line(8'h5A, 1'b1, -1, 0);
    drive_slots(lv, 4*RATIO + 3);
    check("midframe busy", int'(rx_busy_o), 1);
    rstn_i = 1'b0;
    #1;
    check("abort data",  int'(rx_data_o),  0);
    check("abort valid", int'(rx_valid_o), 0);
    check("abort ferr",  int'(rx_ferr_o),  0);
    check("abort busy",  int'(rx_busy_o),  0);
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rstn_i = 1'b1;
    repeat (16) wait_tick();
    #1;
    check("abort no valid", n_valid - v0, 0);
    check("abort no ferr",  n_ferr - f0, 0);
    run_frame("c3", 8'hC3, 1'b1, -1, 0, 12, 1'b1, 1'b0, 8'hC3);

    // Random frames, expectations from the line-level majority decode
    model_d = 8'hC3;
    for (int n = 0; n < 25; n++) begin
      rd  = 8'($urandom);
      rs  = ($urandom_range(0, 4) != 0);
      rb  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 9)) : -1;
      rsl = int'($urandom_range(0, RATIO - 1));
      rg  = (rs && rb != 9 && $urandom_range(0, 1) != 0) ? 0 : 12;
      lv  = build_line(rd, rs, rb, rsl);
      sm  = maj_of(lv, 9);
      if (sm) for (int k = 1; k <= 8; k++) model_d[k-1] = maj_of(lv, k);
      run_frame("rand", rd, rs, rb, rsl, rg, sm, ~sm, model_d);
    end

    check("valid and ferr together", n_both, 0);
    check("pulse wider than one clk", n_long, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
